// File: rtl/sub_nibble_seq.sv
// Multi-cycle WIDTH-bit subtractor: streams operands one nibble per clock,
// LSB first, through an external 4-bit subtractor stage with a registered borrow.
module sub_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic [3:0]       sub_a,
  output logic [3:0]       sub_b,
  output logic             sub_bin,
  input  logic [3:0]       sub_diff,
  input  logic             sub_bout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             brw_q,    brw_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bout_q,   bout_d;
  logic             last_nib;

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; busy is
  // high for the NIB RUN cycles; done is a single-cycle pulse in DONE, during
  // which result/borrow_out are valid (they stay held until the next completion).
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign borrow_out = bout_q;
  assign last_nib   = (idx_q == IW'(NIB - 1));

  assign sub_a   = busy ? a_q[4*idx_q +: 4] : 4'h0;
  assign sub_b   = busy ? b_q[4*idx_q +: 4] : 4'h0;
  assign sub_bin = busy ? brw_q : 1'b0;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          brw_d   = borrow_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d[4*idx_q +: 4] = sub_diff;
        brw_d               = sub_bout;
        idx_d               = idx_q + 1'b1;
        // The final nibble lands in result in the same edge it is produced.
        if (last_nib) begin
          result_d = acc_d;
          bout_d   = sub_bout;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bout_q   <= bout_d;
    end
  end

endmodule

// File: tb/tb_sub_nibble_seq.sv
// Directed and random checks of sub_nibble_seq (WIDTH=16) driving a
// behavioural 4-bit subtractor stage.
module tb_sub_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        borrow_in;
  logic        busy, done, borrow_out;
  logic [15:0] result;
  logic [3:0]  sub_a, sub_b, sub_diff;
  logic        sub_bin, sub_bout;
  logic [4:0]  stage;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sub_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .result(result),
    .borrow_out(borrow_out), .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
    .sub_diff(sub_diff), .sub_bout(sub_bout)
  );

  // 4-bit subtractor stage: bit 4 of the 5-bit difference is the borrow.
  assign stage    = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
  assign sub_diff = stage[3:0];
  assign sub_bout = stage[4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Returns with the bench at the negedge of the DONE cycle; lat = edges after start edge.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = -1;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
    end
    if (lat < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin);
    op_a      = a;
    op_b      = b;
    borrow_in = bin;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int lat, output int nbusy);
    @(negedge clk);
    issue(a, b, bin);
    wait_done(lat, nbusy);
  endtask

  int          lat, nbusy, ndone;
  logic [15:0] ra, rb, cap;
  logic        rbin;
  logic [16:0] model;

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 16'h0);
    check_eq("rst_bout", borrow_out, 0);
    check_eq("rst_sub_a", sub_a, 0);
    rst = 1'b0;

    // 1: basic operation with latency and busy length
    run_op(16'h1234, 16'h0234, 1'b0, lat, nbusy);
    check_eq("t1_result", result, 16'h1000);
    check_eq("t1_bout", borrow_out, 0);
    check_eq("t1_latency", lat, 4);
    check_eq("t1_busy_cycles", nbusy, 4);
    check_eq("t1_busy_in_done", busy, 0);
    @(negedge clk);
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_idle_sub_b", sub_b, 0);
    check_eq("t1_idle_sub_bin", sub_bin, 0);

    // 2: full borrow ripple
    run_op(16'h0000, 16'h0001, 1'b0, lat, nbusy);
    check_eq("t2_result", result, 16'hFFFF);
    check_eq("t2_bout", borrow_out, 1);

    // 3: borrow_in consumed
    run_op(16'h8000, 16'h7FFF, 1'b1, lat, nbusy);
    check_eq("t3_result", result, 16'h0000);
    check_eq("t3_bout", borrow_out, 0);

    // 4: start and operand changes during RUN are ignored
    @(negedge clk);
    issue(16'h5555, 16'h1111, 1'b0);
    @(negedge clk);
    op_a = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op_a = 16'hAAAA;
    ndone = 0;
    cap = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        cap = result;
      end
    end
    check_eq("t4_done_count", ndone, 1);
    check_eq("t4_result", cap, 16'h4444);
    check_eq("t4_result_held", result, 16'h4444);

    // 5: reset mid-RUN abandons the operation
    @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    check_eq("t5_result", result, 16'h0);
    check_eq("t5_sub_a", sub_a, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("t5_no_done", ndone, 0);
    run_op(16'd5, 16'd3, 1'b0, lat, nbusy);
    check_eq("t5_result2", result, 16'h0002);
    check_eq("t5_bout2", borrow_out, 0);

    // 6: back-to-back start in the DONE cycle
    run_op(16'h00F0, 16'h0010, 1'b0, lat, nbusy);
    check_eq("t6a_result", result, 16'h00E0);
    issue(16'h0100, 16'h0101, 1'b0);
    check_eq("t6_busy_b2b", busy, 1);
    check_eq("t6_result_held", result, 16'h00E0);
    wait_done(lat, nbusy);
    check_eq("t6b_latency", lat, 4);
    check_eq("t6b_result", result, 16'hFFFF);
    check_eq("t6b_bout", borrow_out, 1);

    // 6: random back-to-back operations against a reference model
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      model = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
      issue(ra, rb, rbin);
      wait_done(lat, nbusy);
      check_eq("rnd_result", result, model[15:0]);
      check_eq("rnd_bout", borrow_out, model[16]);
      if (lat != 4) check_eq("rnd_latency", lat, 4);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
